// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned DEPTH_DEF = 64;

  function automatic logic rf_addr_valid(
    input int unsigned addr,
    input int unsigned depth,
    input bit          zero_reg
  );
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-address write-port priority select; highest-index port wins.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned NUM_WRITE = 1,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                      en_i,
  input  logic [NUM_WRITE*$clog2(DEPTH)-1:0] rd_i,
  input  logic [NUM_WRITE-1:0]      rd_write_i,
  input  logic [NUM_WRITE*XLEN-1:0] rd_value_i,
  output logic [DEPTH-1:0]          we_o,
  output logic [DEPTH*XLEN-1:0]     data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  always_comb begin
    we_o   = '0;
    data_o = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (en_i && rd_write_i[j] &&
          rf_addr_valid(32'(rd_i[j*AW +: AW]),
                        DEPTH, ZERO_REG != 0)) begin
        we_o[rd_i[j*AW +: AW]] = 1'b1;
        data_o[rd_i[j*AW +: AW]*XLEN +: XLEN] =
          rd_value_i[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with clear sequencer and stall-held reads.
// Define REGFILE_BYPASS_EN for write-first same-cycle bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned NUM_WRITE = 1,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_in,
  input  logic                      clear_in,
  output logic                      ready_out,
  input  logic [NUM_READ*$clog2(DEPTH)-1:0] rs_in,
  output logic [NUM_READ*XLEN-1:0]  rs_value_out,
  input  logic [NUM_WRITE*$clog2(DEPTH)-1:0] rd_in,
  input  logic [NUM_WRITE-1:0]      rd_write_in,
  input  logic [NUM_WRITE*XLEN-1:0] rd_value_in
);

  localparam int unsigned AW = $clog2(DEPTH);

  rf_state_e state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [NUM_READ*XLEN-1:0] rs_q, rs_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic                  wr_en;
  logic [DEPTH-1:0]      wr_we;
  logic [DEPTH*XLEN-1:0] wr_data;
  logic [AW-1:0]         ra [NUM_READ];

  assign ready_out    = (state_q == RF_RUN);
  assign rs_value_out = rs_q;
  assign wr_en        = (state_q == RF_RUN) && !clear_in;

  regfile_wr_arb #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .NUM_WRITE (NUM_WRITE),
    .ZERO_REG  (ZERO_REG)
  ) u_wr_arb (
    .en_i       (wr_en),
    .rd_i       (rd_in),
    .rd_write_i (rd_write_in),
    .rd_value_i (rd_value_in),
    .we_o       (wr_we),
    .data_o     (wr_data)
  );

  for (genvar g = 0; g < NUM_READ; g++) begin : g_ra
    assign ra[g] = rs_in[g*AW +: AW];
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      RF_INIT: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clear_in) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d   = RF_RUN;
          clr_ptr_d = '0;
        end
      end
      RF_RUN: begin
        if (clear_in) begin
          state_d   = RF_INIT;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = RF_INIT;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Reads sample the pre-edge array; bypass forwards this cycle's write.
  always_comb begin
    rs_d = rs_q;
    for (int i = 0; i < NUM_READ; i++) begin
      if (state_q != RF_RUN) begin
        rs_d[i*XLEN +: XLEN] = '0;
      end else if (!stall_in) begin
        if (!rf_addr_valid(32'(ra[i]), DEPTH, ZERO_REG != 0))
          rs_d[i*XLEN +: XLEN] = '0;
`ifdef REGFILE_BYPASS_EN
        else if (wr_we[ra[i]])
          rs_d[i*XLEN +: XLEN] = wr_data[ra[i]*XLEN +: XLEN];
`endif
        else
          rs_d[i*XLEN +: XLEN] = mem_q[ra[i]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RF_INIT;
      clr_ptr_q <= '0;
      rs_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rs_q      <= rs_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int a = 0; a < DEPTH; a++) begin
      if (state_q == RF_INIT && clr_ptr_q == AW'(a))
        mem_q[a] <= '0;
      else if (wr_we[a])
        mem_q[a] <= wr_data[a*XLEN +: XLEN];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a cycle-level behavioural model.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic         clear = 1'b0;
  logic         ready;
  logic [11:0]  rs = '0;
  logic [127:0] rs_val;
  logic [11:0]  rd = '0;
  logic [1:0]   rdw = '0;
  logic [127:0] rdv = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(64), .DEPTH(64), .NUM_READ(2),
    .NUM_WRITE(2), .ZERO_REG(1)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .stall_in     (stall),
    .clear_in     (clear),
    .ready_out    (ready),
    .rs_in        (rs),
    .rs_value_out (rs_val),
    .rd_in        (rd),
    .rd_write_in  (rdw),
    .rd_value_in  (rdv)
  );

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Model: array of values, cycles left in clear, expected outputs.
  logic [63:0] mm [64];
  logic [63:0] e_rs [2];
  int          init_left = 64;
  logic        e_rdy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      init_left = 64;
      e_rs[0] = '0;
      e_rs[1] = '0;
    end else if (init_left > 0) begin
      e_rs[0] = '0;
      e_rs[1] = '0;
      if (clear) init_left = 64;
      else begin
        init_left--;
        if (init_left == 0)
          for (int k = 0; k < 64; k++) mm[k] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!stall) begin
          int a;
          logic [63:0] v;
          a = int'(rs[i*6 +: 6]);
          v = '0;
          if (a != 0) begin
            v = mm[a];
`ifdef REGFILE_BYPASS_EN
            if (!clear)
              for (int j = 0; j < 2; j++)
                if (rdw[j] && int'(rd[j*6 +: 6]) == a)
                  v = rdv[j*64 +: 64];
`endif
          end
          e_rs[i] = v;
        end
      end
      if (clear) init_left = 64;
      else
        for (int j = 0; j < 2; j++)
          if (rdw[j] && rd[j*6 +: 6] != 0)
            mm[rd[j*6 +: 6]] = rdv[j*64 +: 64];
    end
    e_rdy = (init_left == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", 64'(ready), 64'(e_rdy));
      chk("rs0", rs_val[63:0], e_rs[0]);
      chk("rs1", rs_val[127:64], e_rs[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int j, input int a,
                    input logic [63:0] v);
    rdw[j] = 1'b1;
    rd[j*6 +: 6] = 6'(a);
    rdv[j*64 +: 64] = v;
  endtask

  task automatic wait_ready(input string n);
    int c;
    c = 0;
    while (!ready && c < 200) begin
      step();
      c++;
    end
    chk(n, 64'(c), 64'd64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rs", rs_val[63:0], 64'd0);
    rst = 1'b0;
    wait_ready("init_lat");
    for (int i = 0; i < 64; i++) begin
      rs = {6'(63 - i), 6'(i)};
      step();
    end
    chk("zero_read", rs_val[63:0], 64'd0);

    wr(0, 5, 64'hDEAD_BEEF_0123_4567);
    rs[5:0] = 6'd5;
    step();
    rdw = '0;
    step();
    chk("x5", rs_val[63:0], 64'hDEAD_BEEF_0123_4567);
    wr(0, 0, 64'hFFFF);
    rs[5:0] = 6'd0;
    step();
    rdw = '0;
    step();
    chk("x0", rs_val[63:0], 64'd0);

    wr(0, 7, 64'h11);
    step();
    rdw = '0;
    rs[5:0] = 6'd7;
    step();
    chk("x7_pre", rs_val[63:0], 64'h11);
    stall = 1'b1;
    wr(0, 7, 64'h22);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_hold", rs_val[63:0], 64'h11);
    end
    stall = 1'b0;
    rdw = '0;
    step();
    chk("x7_post", rs_val[63:0], 64'h22);

    wr(0, 9, 64'hA);
    wr(1, 9, 64'hB);
    rs = {6'd9, 6'd9};
    step();
    rdw = '0;
    step();
    chk("x9_conf", rs_val[127:64], 64'hB);

    wr(0, 3, 64'h44);
    step();
    wr(1, 3, 64'h55);
    rs[5:0] = 6'd3;
    step();
    rdw = '0;
`ifdef REGFILE_BYPASS_EN
    chk("bypass", rs_val[63:0], 64'h55);
`else
    chk("bypass", rs_val[63:0], 64'h44);
`endif
    step();
    chk("x3_late", rs_val[63:0], 64'h55);

    wr(0, 10, 64'hFF);
    rs[5:0] = 6'd10;
    step();
    rdw = '0;
    step();
    chk("x10", rs_val[63:0], 64'hFF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_ready", 64'(ready), 64'd0);
    begin
      int c;
      c = 0;
      while (!ready && c < 200) begin
        wr(0, 10, 64'hAA);
        step();
        c++;
      end
      chk("clr_lat", 64'(c), 64'd64);
    end
    rdw = '0;
    step();
    chk("x10_clr", rs_val[63:0], 64'd0);

    wr(0, 12, 64'h77);
    step();
    rdw = '0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    chk("mid_rst", 64'(ready), 64'd0);
    rst = 1'b0;
    wait_ready("rst_lat");
    rs[5:0] = 6'd12;
    step();
    chk("x12_clr", rs_val[63:0], 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
